arm_alu: RTL and testbench
==========================

// Module: arm_alu
// PURPOSE
//   ARM-style data-processing ALU in the CPU execute stage. Combines operand Rn with the
//   barrel-shifter output Op2 under a 4-bit ARM opcode. Produces the result word, the
//   next CNZV flags and a register-writeback enable. Outputs are registered: one clock,
//   asynchronous active-low reset.
// PARAMETERS
//   WORD_WIDTH  32  operand/result width (codebase `WordWidth)
// PORTS
//   clk              in   1     system clock, rising edge
//   rst_n            in   1     asynchronous active-low reset
//   in_Rn            in   W     first operand (register Rn)
//   in_Op2           in   W     second operand from barrel shifter
//   in_Barrel_carry  in   1     shifter carry-out, used as C for logical ops
//   in_Opcode        in   4     ALUType opcode (ARM encoding, below)
//   in_CNZV          in   4     current flags {C,N,Z,V}: bit3=C, bit2=N, bit1=Z, bit0=V
//   in_Set_cond      in   1     S bit: 1 = update flags from this op
//   out_Y            out  W     result (registered)
//   out_CNZV         out  4     next flags {C,N,Z,V} (registered)
//   out_Writeback    out  1     1 = out_Y must be written to Rd (registered)
// BEHAVIOUR
//   - Reset (rst_n=0, async): out_Y=0, out_CNZV=4'b0000, out_Writeback=0.
//   - Latency: inputs sampled on a rising clk edge; outputs valid after that edge. No handshake;
//     a new op is accepted every cycle.
//   - Opcodes (ARM): 0 AND Rn&Op2 | 1 EOR Rn^Op2 | 2 SUB Rn-Op2 | 3 RSB Op2-Rn | 4 ADD Rn+Op2 |
//     5 ADC Rn+Op2+C | 6 SBC Rn-Op2-!C | 7 RSC Op2-Rn-!C | 8 TST AND | 9 TEQ EOR | A CMP SUB |
//     B CMN ADD | C ORR Rn|Op2 | D MOV Op2 | E BIC Rn&~Op2 | F MVN ~Op2.
//   - C for ADC/SBC/RSC is in_CNZV[3].
//   - Arithmetic: compute at W+1 bits and discard the overflow, so results wrap modulo 2^W.
//     Subtraction is a + ~b + cin. SUB/CMP/RSB use cin=1; SBC/RSC use cin=C.
//   - Flag C for add-type ops = carry-out.
//   - Flag C for subtract-type ops = NOT borrow, i.e. carry-out of a + ~b + cin.
//   - Flag V: signed overflow. Add: operands same sign and result sign differs.
//     Subtract: operands differ in sign and result sign differs from the minuend.
//   - Logical ops (AND EOR TST TEQ ORR MOV BIC MVN): C=in_Barrel_carry; V=in_CNZV[0] (unchanged).
//   - N = Y[W-1]; Z = (Y==0). These apply to all ops.
//   - Flag write rule: new flags are registered when in_Set_cond=1 or opcode is TST/TEQ/CMP/CMN.
//     In all other cases out_CNZV <= in_CNZV (pass-through).
//   - out_Writeback = 0 for TST/TEQ/CMP/CMN and 1 for all other opcodes.
//   - Test ops (TST/TEQ/CMP/CMN) still drive their computed value onto out_Y.
//   - Boundaries: 0xFFFFFFFF+1 gives Y=0 with C=1, Z=1, V=0.
//     0x7FFFFFFF+1 gives Y=0x80000000 with N=1, V=1, C=0.
//   - X/undefined inputs are not sanitised.
// STRUCTURE
//   - Shared package/header: WORD_WIDTH default, the 16 ALUType_* opcode constants
//     (ALUType_Add=4'h4 etc.), and flag bit indices C=3, N=2, Z=1, V=0.
//   - One sub-module, arm_alu_addsub: W-bit adder a+b+cin returning {sum, cout, v}.
//     All arithmetic ops map onto it by inverting/swapping operands.
//   - Result mux and flag logic are combinational; one output register stage sits behind them.
// TESTING
//   - Reset: assert rst_n=0 -> all outputs 0. Release, then ADD 1+1, S=1 -> Y=2, CNZV=0000, WB=1.
//   - ADD 2+3, S=1, flags 0 -> one clock later Y=5, CNZV=0000, WB=1.
//   - Carry/overflow: ADD 0xFFFFFFFF+1 -> Y=0, CNZV=1010. ADD 0x7FFFFFFF+1 -> Y=0x80000000, CNZV=0101.
//   - Subtract: SUB 3-5 -> Y=0xFFFFFFFE, CNZV=0100. CMP 5,5 -> CNZV=1010, WB=0.
//   - Carry-in: ADC 1+1 with C=1 -> Y=3. SBC 5-2 with C=0 -> Y=2.
//     MOV with S=0 and flags=1111 -> out_CNZV=1111.
//   - Logical: ANDS 0xF0 & 0x0F with Barrel_carry=1, V=1 -> Y=0, CNZV=1011.
//     MVN 0 -> Y=0xFFFFFFFF.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Shared definitions for the ARM data-processing ALU: word width, opcode encodings, flag bit positions.
package arm_alu_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [3:0] ALUType_And = 4'h0;
  localparam logic [3:0] ALUType_Eor = 4'h1;
  localparam logic [3:0] ALUType_Sub = 4'h2;
  localparam logic [3:0] ALUType_Rsb = 4'h3;
  localparam logic [3:0] ALUType_Add = 4'h4;
  localparam logic [3:0] ALUType_Adc = 4'h5;
  localparam logic [3:0] ALUType_Sbc = 4'h6;
  localparam logic [3:0] ALUType_Rsc = 4'h7;
  localparam logic [3:0] ALUType_Tst = 4'h8;
  localparam logic [3:0] ALUType_Teq = 4'h9;
  localparam logic [3:0] ALUType_Cmp = 4'hA;
  localparam logic [3:0] ALUType_Cmn = 4'hB;
  localparam logic [3:0] ALUType_Orr = 4'hC;
  localparam logic [3:0] ALUType_Mov = 4'hD;
  localparam logic [3:0] ALUType_Bic = 4'hE;
  localparam logic [3:0] ALUType_Mvn = 4'hF;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  // Test ops always update flags and never write Rd.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == ALUType_Tst) || (op == ALUType_Teq) ||
           (op == ALUType_Cmp) || (op == ALUType_Cmn);
  endfunction

endpackage

// File: rtl/arm_alu_if.sv
// Operand/result bundle between the execute-stage control and the ALU.
interface arm_alu_if
  import arm_alu_pkg::*;
#(
  parameter int W = WORD_WIDTH
);
  logic [W-1:0] in_Rn;
  logic [W-1:0] in_Op2;
  logic         in_Barrel_carry;
  logic [3:0]   in_Opcode;
  logic [3:0]   in_CNZV;
  logic         in_Set_cond;
  logic [W-1:0] out_Y;
  logic [3:0]   out_CNZV;
  logic         out_Writeback;

  modport master (
    output in_Rn, in_Op2, in_Barrel_carry, in_Opcode, in_CNZV, in_Set_cond,
    input  out_Y, out_CNZV, out_Writeback
  );

  modport slave (
    input  in_Rn, in_Op2, in_Barrel_carry, in_Opcode, in_CNZV, in_Set_cond,
    output out_Y, out_CNZV, out_Writeback
  );
endinterface

// File: rtl/arm_alu_addsub.sv
// W-bit adder a+b+cin with carry-out and signed overflow; subtraction is done by the caller inverting b.
module arm_alu_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_v
);
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];
  // With b already inverted for subtracts, the add-overflow rule covers both cases.
  assign o_v    = (i_a[W-1] == i_b[W-1]) && (w_full[W-1] != i_a[W-1]);
endmodule

// File: rtl/arm_alu.sv
// ARM data-processing ALU: result, next CNZV and writeback enable, one registered stage.
// Accepts a new op every cycle; no backpressure.
module arm_alu
  import arm_alu_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  arm_alu_if.slave alu_bus
);
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_cin;
  logic         w_arith;
  logic [W-1:0] w_sum;
  logic         w_cout;
  logic         w_ovf;
  logic [W-1:0] w_logic;
  logic [W-1:0] w_y;
  logic         w_test;
  logic         w_c;
  logic         w_v;
  logic [3:0]   w_flags;
  logic [3:0]   w_flags_next;

  logic [W-1:0] r_y;
  logic [3:0]   r_cnzv;
  logic         r_wb;

  // Map every arithmetic op onto a single adder by swapping/inverting operands.
  always_comb begin
    w_a     = alu_bus.in_Rn;
    w_b     = alu_bus.in_Op2;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    case (alu_bus.in_Opcode)
      ALUType_Sub, ALUType_Cmp: begin
        w_b   = ~alu_bus.in_Op2;
        w_cin = 1'b1;
      end
      ALUType_Rsb: begin
        w_a   = alu_bus.in_Op2;
        w_b   = ~alu_bus.in_Rn;
        w_cin = 1'b1;
      end
      ALUType_Add, ALUType_Cmn: w_cin = 1'b0;
      ALUType_Adc: w_cin = alu_bus.in_CNZV[FLAG_C];
      ALUType_Sbc: begin
        w_b   = ~alu_bus.in_Op2;
        w_cin = alu_bus.in_CNZV[FLAG_C];
      end
      ALUType_Rsc: begin
        w_a   = alu_bus.in_Op2;
        w_b   = ~alu_bus.in_Rn;
        w_cin = alu_bus.in_CNZV[FLAG_C];
      end
      default: w_arith = 1'b0;
    endcase
  end

  arm_alu_addsub #(.W(W)) u_addsub (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_v    (w_ovf)
  );

  always_comb begin
    w_logic = '0;
    case (alu_bus.in_Opcode)
      ALUType_And, ALUType_Tst: w_logic = alu_bus.in_Rn & alu_bus.in_Op2;
      ALUType_Eor, ALUType_Teq: w_logic = alu_bus.in_Rn ^ alu_bus.in_Op2;
      ALUType_Orr:              w_logic = alu_bus.in_Rn | alu_bus.in_Op2;
      ALUType_Mov:              w_logic = alu_bus.in_Op2;
      ALUType_Bic:              w_logic = alu_bus.in_Rn & ~alu_bus.in_Op2;
      ALUType_Mvn:              w_logic = ~alu_bus.in_Op2;
      default:                  w_logic = '0;
    endcase
  end

  assign w_y    = w_arith ? w_sum : w_logic;
  assign w_test = is_test_op(alu_bus.in_Opcode);
  // Logical ops take C from the shifter and leave V untouched.
  assign w_c    = w_arith ? w_cout : alu_bus.in_Barrel_carry;
  assign w_v    = w_arith ? w_ovf  : alu_bus.in_CNZV[FLAG_V];

  assign w_flags      = {w_c, w_y[W-1], (w_y == '0), w_v};
  assign w_flags_next = (alu_bus.in_Set_cond || w_test) ? w_flags : alu_bus.in_CNZV;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y    <= '0;
      r_cnzv <= 4'b0000;
      r_wb   <= 1'b0;
    end else begin
      r_y    <= w_y;
      r_cnzv <= w_flags_next;
      r_wb   <= ~w_test;
    end
  end

  assign alu_bus.out_Y         = r_y;
  assign alu_bus.out_CNZV      = r_cnzv;
  assign alu_bus.out_Writeback = r_wb;
endmodule

// File: tb/tb_arm_alu.sv
// Scoreboarded bench for arm_alu: directed corner cases then randomized ops against an arithmetic model.
module tb_arm_alu;
  import arm_alu_pkg::*;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    logic        wb;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  logic drv_vld;
  exp_t exp_q[$];
  int   cmp_cnt;
  int   err_cnt;

  arm_alu_if #(.W(32)) alu_bus ();

  arm_alu #(.W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .alu_bus (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference model written directly from the ARM arithmetic rules using wide signed/unsigned integers.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] op2,
                                 input logic bc, input logic [3:0] fl, input logic s);
    exp_t   e;
    logic [31:0] y;
    logic   c, v, test, arith;
    longint x, z, brw, cin, ures, sres;
    y = 0; c = bc; v = fl[0]; arith = 1'b0;
    x = 0; z = 0; brw = 0; cin = 0;
    test = (op == 4'h8) || (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
    case (op)
      4'h0, 4'h8: y = rn & op2;
      4'h1, 4'h9: y = rn ^ op2;
      4'hC:       y = rn | op2;
      4'hD:       y = op2;
      4'hE:       y = rn & ~op2;
      4'hF:       y = ~op2;
      default:    arith = 1'b1;
    endcase
    if (op == 4'h4 || op == 4'hB || op == 4'h5) begin
      cin  = (op == 4'h5) ? longint'(fl[3]) : 0;
      ures = longint'(rn) + longint'(op2) + cin;
      sres = longint'($signed(rn)) + longint'($signed(op2)) + cin;
      y = ures[31:0];
      c = (ures > 64'sd4294967295);
      v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    end else if (arith) begin
      brw = (op == 4'h6 || op == 4'h7) ? longint'(!fl[3]) : 0;
      if (op == 4'h3 || op == 4'h7) begin
        ures = longint'(op2) - longint'(rn) - brw;
        sres = longint'($signed(op2)) - longint'($signed(rn)) - brw;
      end else begin
        ures = longint'(rn) - longint'(op2) - brw;
        sres = longint'($signed(rn)) - longint'($signed(op2)) - brw;
      end
      y = ures[31:0];
      c = (ures >= 0);
      v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    end
    e.y    = y;
    e.f    = (s || test) ? {c, y[31], (y == 32'd0), v} : fl;
    e.wb   = !test;
    e.name = "rand";
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] op2,
                       input logic bc, input logic [3:0] fl, input logic s, input exp_t e);
    alu_bus.in_Opcode       = op;
    alu_bus.in_Rn           = rn;
    alu_bus.in_Op2          = op2;
    alu_bus.in_Barrel_carry = bc;
    alu_bus.in_CNZV         = fl;
    alu_bus.in_Set_cond     = s;
    drv_vld                 = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic directed(input string nm, input logic [3:0] op, input logic [31:0] rn,
                          input logic [31:0] op2, input logic bc, input logic [3:0] fl, input logic s,
                          input logic [31:0] ey, input logic [3:0] ef, input logic ewb);
    exp_t e;
    e.y = ey; e.f = ef; e.wb = ewb; e.name = nm;
    issue(op, rn, op2, bc, fl, s, e);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Monitor: every clock that consumed a driven op must present the head of the queue.
  initial begin
    logic seen;
    exp_t e;
    forever begin
      @(posedge clk);
      seen = drv_vld;
      #1;
      if (seen) begin
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL sb_underflow: got output with empty queue, required an expectation");
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_y"},  alu_bus.out_Y, e.y);
          chk({e.name, "_f"},  {28'd0, alu_bus.out_CNZV}, {28'd0, e.f});
          chk({e.name, "_wb"}, {31'd0, alu_bus.out_Writeback}, {31'd0, e.wb});
        end
      end
    end
  end

  initial begin
    logic [3:0]  op, fl;
    logic [31:0] rn, op2;
    logic        bc, s;
    cmp_cnt = 0;
    err_cnt = 0;
    drv_vld = 1'b0;
    rst_n   = 1'b0;
    alu_bus.in_Opcode = 4'h4; alu_bus.in_Rn = 32'd1; alu_bus.in_Op2 = 32'd1;
    alu_bus.in_Barrel_carry = 1'b1; alu_bus.in_CNZV = 4'hF; alu_bus.in_Set_cond = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_y",  alu_bus.out_Y, 32'd0);
    chk("rst_f",  {28'd0, alu_bus.out_CNZV}, 32'd0);
    chk("rst_wb", {31'd0, alu_bus.out_Writeback}, 32'd0);
    rst_n = 1'b1;

    directed("add_1_1",   ALUType_Add, 32'd1, 32'd1, 1'b0, 4'h0, 1'b1, 32'd2, 4'b0000, 1'b1);
    directed("add_2_3",   ALUType_Add, 32'd2, 32'd3, 1'b0, 4'h0, 1'b1, 32'd5, 4'b0000, 1'b1);
    directed("add_wrap",  ALUType_Add, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'h0, 1'b1, 32'd0, 4'b1010, 1'b1);
    directed("add_ovf",   ALUType_Add, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'h0, 1'b1, 32'h8000_0000, 4'b0101, 1'b1);
    directed("sub_3_5",   ALUType_Sub, 32'd3, 32'd5, 1'b0, 4'h0, 1'b1, 32'hFFFF_FFFE, 4'b0100, 1'b1);
    directed("cmp_5_5",   ALUType_Cmp, 32'd5, 32'd5, 1'b0, 4'h0, 1'b0, 32'd0, 4'b1010, 1'b0);
    directed("adc_c1",    ALUType_Adc, 32'd1, 32'd1, 1'b0, 4'b1000, 1'b0, 32'd3, 4'b1000, 1'b1);
    directed("sbc_c0",    ALUType_Sbc, 32'd5, 32'd2, 1'b0, 4'b0000, 1'b0, 32'd2, 4'b0000, 1'b1);
    directed("mov_pass",  ALUType_Mov, 32'd9, 32'h1234, 1'b0, 4'b1111, 1'b0, 32'h1234, 4'b1111, 1'b1);
    directed("ands",      ALUType_And, 32'hF0, 32'h0F, 1'b1, 4'b0001, 1'b1, 32'd0, 4'b1011, 1'b1);
    directed("mvn_0",     ALUType_Mvn, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    directed("rsb_2_7",   ALUType_Rsb, 32'd2, 32'd7, 1'b0, 4'b0000, 1'b1, 32'd5, 4'b1000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      op  = 4'($urandom_range(0, 15));
      rn  = pick();
      op2 = pick();
      bc  = 1'($urandom_range(0, 1));
      fl  = 4'($urandom_range(0, 15));
      s   = 1'($urandom_range(0, 1));
      issue(op, rn, op2, bc, fl, s, model(op, rn, op2, bc, fl, s));
    end

    directed("mvn_last",  ALUType_Mvn, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b1, 32'hFFFF_FFFF, 4'b0100, 1'b1);
    drv_vld = 1'b0;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
    end

    // Reset asserted between clock edges must clear the outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y",  alu_bus.out_Y, 32'd0);
    chk("arst_f",  {28'd0, alu_bus.out_CNZV}, 32'd0);
    chk("arst_wb", {31'd0, alu_bus.out_Writeback}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
